// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: PC commands, instruction/PC feedback and the
// datapath EXEC valid/done handshake.
//   master : the sequencer (drives PC commands and EXEC_*)
//   slave  : PC block, instruction memory and datapath
interface fetch_sequencer_if #(
    parameter int SHORT_W = 4
);
    logic [7:0]         INSTR;
    logic [7:0]         PC;
    logic               ZFLAG;
    logic               EXEC_DONE;
    logic               IncPC;
    logic               LoadPC;
    logic               SelPC;
    logic [7:0]         A;
    logic [SHORT_W-1:0] B;
    logic               EXEC_VALID;
    logic [7:0]         EXEC_OP;
    logic               HALTED;
    logic               STK_ERR;

    modport master (
        input  INSTR, PC, ZFLAG, EXEC_DONE,
        output IncPC, LoadPC, SelPC, A, B,
        output EXEC_VALID, EXEC_OP, HALTED, STK_ERR
    );

    modport slave (
        output INSTR, PC, ZFLAG, EXEC_DONE,
        input  IncPC, LoadPC, SelPC, A, B,
        input  EXEC_VALID, EXEC_OP, HALTED, STK_ERR
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-side sequencer: fetches/decodes opcodes, commands the PC
// block, runs jumps/branches/call/return and hands other ops to the datapath.
// Ports: CLK, CLB (async active-low reset), bus (fetch_sequencer_if.master:
//   INSTR/PC/ZFLAG/EXEC_DONE in; IncPC/LoadPC/SelPC/A/B, EXEC_VALID/EXEC_OP,
//   HALTED, STK_ERR out).
// Option: define CALL_STACK_EN for the STACK_DEPTH-entry return stack;
//   without it opcodes 0x4/0x5 go to the datapath and STK_ERR is 0.
module fetch_sequencer #(
    parameter int STACK_DEPTH = 4,
    parameter int SHORT_W     = 4
) (
    input logic                CLK,
    input logic                CLB,
    fetch_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        S_INIT,
        S_FETCH,
        S_DECODE,
        S_OPER,
        S_EXEC,
        S_HALT
    } state_t;

    state_t state_q;
    state_t nxt;

    logic [7:0] ir_q;
    logic [3:0] opc;

    logic               inc_c;
    logic               load_c;
    logic               sel_c;
    logic [7:0]         a_c;
    logic [SHORT_W-1:0] b_c;
    logic               valid_c;
    logic [7:0]         op_c;
    logic               halt_c;
    logic               push_c;
    logic               pop_c;
    logic               err_c;

    logic       dec_nop;
    logic       dec_jmps;
    logic       dec_oper;
    logic       dec_ret;
    logic       dec_ret_err;
    logic       dec_halt;
    logic       is_call;
    logic [7:0] top;

    assign opc = ir_q[7:4];

    // BRZ folds into NOP or JMPS depending on the zero flag.
    assign dec_nop  = (opc == 4'h0) || (opc == 4'h3 && !bus.ZFLAG);
    assign dec_jmps = (opc == 4'h1) || (opc == 4'h3 && bus.ZFLAG);
    assign dec_halt = (opc == 4'hF);

`ifdef CALL_STACK_EN
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [7:0]     stk_q [STACK_DEPTH];
    logic [SPW-1:0] sp_q;
    logic           err_q;
    logic           full;
    logic [IW-1:0]  top_i;
    logic [IW-1:0]  push_i;
    logic [7:0]     ret_addr;

    assign full        = (sp_q == SPW'(STACK_DEPTH));
    assign top_i       = IW'(sp_q - 1'b1);
    assign push_i      = IW'(sp_q);
    assign top         = stk_q[top_i];
    // In OPER the PC points at the target byte, so return lands after it.
    assign ret_addr    = bus.PC + 8'd1;
    assign dec_oper    = (opc == 4'h2) || (opc == 4'h4);
    assign dec_ret     = (opc == 4'h5) && (sp_q != '0);
    assign dec_ret_err = (opc == 4'h5) && (sp_q == '0);
    assign is_call     = (opc == 4'h4);
`else
    assign top         = '0;
    assign dec_oper    = (opc == 4'h2);
    assign dec_ret     = 1'b0;
    assign dec_ret_err = 1'b0;
    assign is_call     = 1'b0;

    logic unused_stk;
    assign unused_stk = push_c | pop_c | err_c | (^bus.PC);
`endif

    always_comb begin
        inc_c   = 1'b0;
        load_c  = 1'b0;
        sel_c   = 1'b0;
        a_c     = '0;
        b_c     = '0;
        valid_c = 1'b0;
        op_c    = '0;
        halt_c  = 1'b0;
        push_c  = 1'b0;
        pop_c   = 1'b0;
        err_c   = 1'b0;
        nxt     = state_q;
        unique case (state_q)
            S_INIT: begin
                // IncPC with LoadPC is the PC-clear command.
                inc_c  = 1'b1;
                load_c = 1'b1;
                nxt    = S_FETCH;
            end
            S_FETCH: begin
                nxt = S_DECODE;
            end
            S_DECODE: begin
                nxt = S_FETCH;
                unique case (1'b1)
                    dec_nop: begin
                        inc_c = 1'b1;
                    end
                    dec_jmps: begin
                        load_c = 1'b1;
                        b_c    = SHORT_W'(ir_q[3:0]);
                    end
                    dec_oper: begin
                        inc_c = 1'b1;
                        nxt   = S_OPER;
                    end
                    dec_ret: begin
                        load_c = 1'b1;
                        sel_c  = 1'b1;
                        a_c    = top;
                        pop_c  = 1'b1;
                    end
                    dec_ret_err: begin
                        inc_c = 1'b1;
                        err_c = 1'b1;
                    end
                    dec_halt: begin
                        halt_c = 1'b1;
                        nxt    = S_HALT;
                    end
                    default: begin
                        nxt = S_EXEC;
                    end
                endcase
            end
            S_OPER: begin
                load_c = 1'b1;
                sel_c  = 1'b1;
                a_c    = bus.INSTR;
                push_c = is_call;
                nxt    = S_FETCH;
            end
            S_EXEC: begin
                valid_c = 1'b1;
                op_c    = ir_q;
                if (bus.EXEC_DONE) begin
                    inc_c = 1'b1;
                    nxt   = S_FETCH;
                end
            end
            S_HALT: begin
                halt_c = 1'b1;
            end
            default: begin
                nxt = S_INIT;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge CLB) begin
        if (!CLB) begin
            state_q <= S_INIT;
            ir_q    <= '0;
`ifdef CALL_STACK_EN
            sp_q    <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stk_q[i] <= '0;
            end
`endif
        end else begin
            state_q <= nxt;
            if (state_q == S_FETCH) begin
                ir_q <= bus.INSTR;
            end
`ifdef CALL_STACK_EN
            // A full stack drops the push; the jump itself still happens.
            if (push_c) begin
                if (full) begin
                    err_q <= 1'b1;
                end else begin
                    stk_q[push_i] <= ret_addr;
                    sp_q          <= sp_q + 1'b1;
                end
            end
            if (pop_c) begin
                sp_q <= sp_q - 1'b1;
            end
            if (err_c) begin
                err_q <= 1'b1;
            end
`endif
        end
    end

    assign bus.IncPC      = inc_c;
    assign bus.LoadPC     = load_c;
    assign bus.SelPC      = sel_c;
    assign bus.A          = a_c;
    assign bus.B          = b_c;
    assign bus.EXEC_VALID = valid_c;
    assign bus.EXEC_OP    = op_c;
    assign bus.HALTED     = halt_c;
`ifdef CALL_STACK_EN
    assign bus.STK_ERR    = err_q;
`else
    assign bus.STK_ERR    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: PC block + ROM environment, instruction-level
// reference model, directed cases and a randomized program run.
module tb_fetch_sequencer;

    localparam int DEPTH = 4;

    logic CLK;
    logic CLB;

    fetch_sequencer_if bus_if ();

    fetch_sequencer #(
        .STACK_DEPTH (DEPTH),
        .SHORT_W     (4)
    ) dut (
        .CLK (CLK),
        .CLB (CLB),
        .bus (bus_if.master)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Environment: instruction ROM and PC block.
    logic [7:0] rom [256];
    logic [7:0] pc_env;

    assign bus_if.INSTR = rom[pc_env];
    assign bus_if.PC    = pc_env;

    always @(posedge CLK) begin
        if (bus_if.IncPC && bus_if.LoadPC)
            pc_env <= 8'h00;
        else if (bus_if.LoadPC)
            pc_env <= bus_if.SelPC ? bus_if.A : {4'h0, bus_if.B};
        else if (bus_if.IncPC)
            pc_env <= pc_env + 8'd1;
    end

    // Reference model state.
    logic [7:0] m_pc;
    logic [7:0] m_stk [$];
    logic       m_err;

    int total;
    int bad;

    function automatic logic [25:0] exp_o(
        input logic       inc,
        input logic       load,
        input logic       sel,
        input logic [7:0] a,
        input logic [3:0] b,
        input logic       v,
        input logic [7:0] op,
        input logic       h,
        input logic       e
    );
        return {inc, load, sel, a, b, v, op, h, e};
    endfunction

    function automatic logic [25:0] obs();
        return {bus_if.IncPC, bus_if.LoadPC, bus_if.SelPC,
                bus_if.A, bus_if.B, bus_if.EXEC_VALID,
                bus_if.EXEC_OP, bus_if.HALTED, bus_if.STK_ERR};
    endfunction

    task automatic check(
        input string       tag,
        input logic [25:0] o,
        input logic [25:0] e
    );
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic check_pc(input string tag);
        total++;
        assert (pc_env === m_pc) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, pc_env, m_pc);
        end
    endtask

    // One clock: drive inputs, check at negedge, advance to posedge+1.
    task automatic step(
        input logic [25:0] e,
        input string       tag,
        input logic        z,
        input logic        done
    );
        bus_if.ZFLAG     = z;
        bus_if.EXEC_DONE = done;
        @(negedge CLK);
        check(tag, obs(), e);
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    task automatic do_reset();
        CLB = 1'b0;
        m_pc = 8'h00;
        m_stk.delete();
        m_err = 1'b0;
        step(exp_o(1, 1, 0, 0, 0, 0, 0, 0, 0), "reset", 0, 0);
        step(exp_o(1, 1, 0, 0, 0, 0, 0, 0, 0), "reset", 1, 1);
        CLB = 1'b1;
        step(exp_o(1, 1, 0, 0, 0, 0, 0, 0, 0), "init", 0, 0);
    endtask

    // Execute one instruction at m_pc, checking every cycle.
    task automatic run_instr(input logic z, input int wait_n);
        logic [7:0] ir;
        logic [7:0] nx;
        logic [7:0] tgt;
        logic [3:0] op;
        ir = rom[m_pc];
        op = ir[7:4];
        nx = m_pc + 8'd1;
        step(exp_o(0, 0, 0, 0, 0, 0, 0, 0, m_err), "fetch", z, 0);
        if (op == 4'h0 || (op == 4'h3 && !z)) begin
            step(exp_o(1, 0, 0, 0, 0, 0, 0, 0, m_err), "nop", z, 0);
            m_pc = nx;
        end else if (op == 4'h1 || (op == 4'h3 && z)) begin
            step(exp_o(0, 1, 0, 0, ir[3:0], 0, 0, 0, m_err),
                 "jmps", z, 0);
            m_pc = {4'h0, ir[3:0]};
        end else if (op == 4'h2) begin
            tgt = rom[nx];
            step(exp_o(1, 0, 0, 0, 0, 0, 0, 0, m_err), "jmpl_dec", z, 0);
            step(exp_o(0, 1, 1, tgt, 0, 0, 0, 0, m_err), "jmpl_tgt", z, 0);
            m_pc = tgt;
        end
`ifdef CALL_STACK_EN
        else if (op == 4'h4) begin
            logic [7:0] ret;
            tgt = rom[nx];
            ret = nx + 8'd1;
            step(exp_o(1, 0, 0, 0, 0, 0, 0, 0, m_err), "call_dec", z, 0);
            step(exp_o(0, 1, 1, tgt, 0, 0, 0, 0, m_err), "call_tgt", z, 0);
            if (m_stk.size() < DEPTH) m_stk.push_back(ret);
            else m_err = 1'b1;
            m_pc = tgt;
        end else if (op == 4'h5) begin
            if (m_stk.size() > 0) begin
                tgt = m_stk[$];
                step(exp_o(0, 1, 1, tgt, 0, 0, 0, 0, m_err), "ret", z, 0);
                void'(m_stk.pop_back());
                m_pc = tgt;
            end else begin
                step(exp_o(1, 0, 0, 0, 0, 0, 0, 0, m_err),
                     "ret_empty", z, 0);
                m_err = 1'b1;
                m_pc = nx;
            end
        end
`endif
        else if (op == 4'hF) begin
            step(exp_o(0, 0, 0, 0, 0, 0, 0, 1, m_err), "halt_dec", z, 0);
        end else begin
            step(exp_o(0, 0, 0, 0, 0, 0, 0, 0, m_err), "exec_dec", z, 0);
            for (int i = 0; i < wait_n; i++)
                step(exp_o(0, 0, 0, 0, 0, 1, ir, 0, m_err),
                     "exec_wait", z, 0);
            step(exp_o(1, 0, 0, 0, 0, 1, ir, 0, m_err), "exec_done", z, 1);
            m_pc = nx;
        end
        check_pc("pc");
    endtask

    initial begin
        logic [7:0] v;
        total = 0;
        bad   = 0;
        CLB   = 1'b1;
        bus_if.ZFLAG     = 1'b0;
        bus_if.EXEC_DONE = 1'b0;
        clear_rom();
        #3 CLB = 1'b0;
        @(posedge CLK);
        #1;

        // NOP, NOP, HALT; then HALT holds with no PC commands.
        rom[0] = 8'h00; rom[1] = 8'h00; rom[2] = 8'hF0;
        do_reset();
        run_instr(0, 0);
        run_instr(0, 0);
        run_instr(0, 0);
        for (int i = 0; i < 4; i++)
            step(exp_o(0, 0, 0, 0, 0, 0, 0, 1, 0), "halt_hold",
                 1'($urandom), 1'($urandom));
        check_pc("halt_pc");

        // Short jump.
        clear_rom();
        rom[0] = 8'h1A; rom[8'h0A] = 8'hF0;
        do_reset();
        run_instr(0, 0);
        run_instr(0, 0);

        // Long jump.
        clear_rom();
        rom[0] = 8'h20; rom[1] = 8'hC3;
        do_reset();
        run_instr(0, 0);
        run_instr(0, 0);

        // BRZ taken, then not taken.
        clear_rom();
        rom[0] = 8'h35;
        do_reset();
        run_instr(1, 0);
        do_reset();
        run_instr(0, 0);

        // Datapath op with four wait cycles.
        clear_rom();
        rom[0] = 8'h7E;
        do_reset();
        run_instr(0, 4);
        run_instr(0, 0);

        // JMPL at 0xFF takes its operand from 0x00.
        clear_rom();
        rom[0] = 8'h20; rom[1] = 8'hFF; rom[8'hFF] = 8'h20;
        do_reset();
        run_instr(0, 0);
        run_instr(0, 0);
        run_instr(0, 0);

        // Random program, HALT excluded.
        for (int i = 0; i < 256; i++) begin
            do v = 8'($urandom); while (v[7:4] == 4'hF);
            rom[i] = v;
        end
        do_reset();
        for (int i = 0; i < 150; i++)
            run_instr(1'($urandom), int'($urandom_range(0, 3)));

        clear_rom();
`ifdef CALL_STACK_EN
        // Five nested calls then five returns.
        rom[8'h00] = 8'h40; rom[8'h01] = 8'h10;
        rom[8'h10] = 8'h40; rom[8'h11] = 8'h20;
        rom[8'h20] = 8'h40; rom[8'h21] = 8'h30;
        rom[8'h30] = 8'h40; rom[8'h31] = 8'h40;
        rom[8'h40] = 8'h40; rom[8'h41] = 8'h50;
        rom[8'h50] = 8'h50;
        rom[8'h32] = 8'h50;
        rom[8'h22] = 8'h50;
        rom[8'h12] = 8'h50;
        rom[8'h02] = 8'h50;
        do_reset();
        for (int i = 0; i < 10; i++) run_instr(0, 0);
`else
        do_reset();
`endif

        // Reset in the middle of a datapath op.
        rom[m_pc] = 8'h7E;
        step(exp_o(0, 0, 0, 0, 0, 0, 0, 0, m_err), "mid_fetch", 0, 0);
        step(exp_o(0, 0, 0, 0, 0, 0, 0, 0, m_err), "mid_dec", 0, 0);
        step(exp_o(0, 0, 0, 0, 0, 1, 8'h7E, 0, m_err), "mid_exec", 0, 0);
        @(negedge CLK);
        #2 CLB = 1'b0;
        #1;
        check("async_rst", obs(), exp_o(1, 1, 0, 0, 0, 0, 0, 0, 0));
        @(posedge CLK);
        #1;
        do_reset();
        rom[0] = 8'h00;
        run_instr(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
